// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding and the program counter step between sequential fetches.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FULL  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_t;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: issues one memory request at a time,
// writes each returned word into a circular instruction buffer slot and
// tracks how many buffered words the downstream stage has not consumed.
// A redirect flushes the buffer and restarts fetching at a new pc; a
// response that is still in flight at that point is drained and dropped.
module instr_fetch_seq
  import instr_fetch_pkg::*;
#(
  parameter  int INSTR_WORD_SIZE = 32,
  parameter  int BS              = 16,
  parameter  int ADDR_W          = 32,
  localparam int PTR_W           = (BS > 1) ? $clog2(BS) : 1,
  localparam int OCC_W           = PTR_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       instr_consume,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [INSTR_WORD_SIZE-1:0] mem_rdata,
  output logic [INSTR_WORD_SIZE-1:0] buf_instr,
  output logic [PTR_W-1:0]           buf_index,
  output logic                       buf_wr_pulse,
  output logic [OCC_W-1:0]           occupancy,
  output logic                       full
);

  fetch_state_t        state;
  fetch_state_t        state_next;
  logic [ADDR_W-1:0]   pc;
  logic [PTR_W-1:0]    wr_ptr;
  logic [OCC_W-1:0]    occ_next;
  logic                capture;
  logic                consume_ok;
  logic                drain_needed;

  assign mem_req  = (state == ST_REQ);
  assign mem_addr = pc;
  assign full     = (occupancy == OCC_W'(BS));

  // A redirect cancels any capture or consume in the same cycle; a consume
  // against an empty buffer is meaningless and is dropped.
  assign capture    = (state == ST_WAIT) && mem_rvalid && !redirect_valid;
  assign consume_ok = instr_consume && (occupancy != '0) && !redirect_valid;

  // A response is still owed by memory if we were waiting for it, were just
  // granted, or were already draining one, and it did not arrive this cycle.
  assign drain_needed = ((state == ST_WAIT)  && !mem_rvalid) ||
                        ((state == ST_REQ)   && mem_gnt)     ||
                        ((state == ST_DRAIN) && !mem_rvalid);

  // Occupancy after this cycle's capture and consume; both together cancel.
  always_comb begin
    occ_next = occupancy;
    if (capture && !consume_ok) begin
      occ_next = occupancy + OCC_W'(1);
    end else if (!capture && consume_ok) begin
      occ_next = occupancy - OCC_W'(1);
    end
  end

  // Next-state logic; a redirect takes priority over every other event.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      if (drain_needed) begin
        state_next = ST_DRAIN;
      end else begin
        state_next = fetch_en ? ST_REQ : ST_IDLE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_en && !full) begin
            state_next = ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (occ_next == OCC_W'(BS)) begin
              state_next = ST_FULL;
            end else begin
              state_next = fetch_en ? ST_REQ : ST_IDLE;
            end
          end
        end
        ST_FULL: begin
          if (!full) begin
            state_next = fetch_en ? ST_REQ : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (mem_rvalid) begin
            state_next = fetch_en ? ST_REQ : ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pc, write pointer, occupancy and the registered buffer write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      wr_ptr       <= '0;
      occupancy    <= '0;
      buf_instr    <= '0;
      buf_index    <= '0;
      buf_wr_pulse <= 1'b0;
    end else begin
      buf_wr_pulse <= capture;
      if (redirect_valid) begin
        pc        <= redirect_pc;
        wr_ptr    <= '0;
        occupancy <= '0;
      end else begin
        occupancy <= occ_next;
        if (capture) begin
          buf_instr <= mem_rdata;
          buf_index <= wr_ptr;
          wr_ptr    <= wr_ptr + PTR_W'(1);
          pc        <= pc + ADDR_W'(PC_INC);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: directed scenarios push expected
// grant addresses and buffer writes; a monitor compares them as they occur.
module tb_instr_fetch_seq;

  localparam int IW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_consume = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic [IW-1:0] buf_instr;
  logic [3:0]    buf_index;
  logic          buf_wr_pulse;
  logic [4:0]    occupancy;
  logic          full;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t       wr_q[$];
  logic [31:0]   addr_q[$];

  int n_total = 0;
  int n_bad = 0;
  int grant_seen = 0;
  int write_seen = 0;
  int resp_delay = 0;
  int resp_cnt = 0;
  logic [31:0] resp_addr = '0;
  bit resp_fire = 1'b0;
  bit auto_consume = 1'b0;

  instr_fetch_seq #(.INSTR_WORD_SIZE(IW), .BS(16), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_consume(instr_consume), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .buf_instr(buf_instr), .buf_index(buf_index), .buf_wr_pulse(buf_wr_pulse),
    .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_total++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    n_total++;
    n_bad++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit en, input bit cons, input bit redir,
                               input logic [31:0] rpc);
    fetch_en       = en;
    instr_consume  = cons;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  task automatic expectGrant(input logic [31:0] addr);
    addr_q.push_back(addr);
  endtask

  task automatic expectWord(input logic [31:0] addr, input logic [3:0] idx);
    addr_q.push_back(addr);
    wr_q.push_back({idx, word_for(addr)});
  endtask

  task automatic applyReset();
    step();
    rst_n = 1'b0;
    auto_consume = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) step();
    rst_n = 1'b1;
  endtask

  task automatic waitWrites(input int target, input string name);
    for (int c = 0; c < 300; c++) begin
      if (write_seen >= target) return;
      sample();
    end
    failNow({name, " write timeout"});
  endtask

  task automatic waitGrants(input int target, input string name);
    for (int c = 0; c < 300; c++) begin
      if (grant_seen >= target) return;
      sample();
    end
    failNow({name, " grant timeout"});
  endtask

  // Memory model: grants a pending request and returns data 1+resp_delay
  // cycles later; optionally consumes in the same cycle as each response.
  initial begin
    forever begin
      step();
      resp_fire = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) resp_fire = 1'b1;
      end
      mem_rvalid = resp_fire;
      mem_rdata  = resp_fire ? word_for(resp_addr) : '0;
      if (auto_consume) instr_consume = resp_fire;
      mem_gnt = mem_req && (resp_cnt == 0);
      if (mem_gnt) begin
        resp_cnt  = 1 + resp_delay;
        resp_addr = mem_addr;
      end
    end
  end

  // Monitor: compares every grant and every buffer write against the queues.
  initial begin
    wr_exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_req && mem_gnt) begin
          grant_seen++;
          if (addr_q.size() == 0) begin
            failNow("unexpected grant");
          end else begin
            a = addr_q.pop_front();
            checkOutput("grant addr", mem_addr, a);
          end
        end
        if (buf_wr_pulse) begin
          write_seen++;
          if (wr_q.size() == 0) begin
            failNow("unexpected buffer write");
          end else begin
            e = wr_q.pop_front();
            checkOutput("write index", buf_index, e.idx);
            checkOutput("write data", buf_instr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bw;
    int bg;
    bit hit;

    // Reset values
    applyReset();
    sample();
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset occupancy", occupancy, 0);
    checkOutput("reset full", full, 0);
    checkOutput("reset buf_wr_pulse", buf_wr_pulse, 0);
    checkOutput("reset buf_index", buf_index, 0);
    checkOutput("reset buf_instr", buf_instr, 0);

    // Sequential fill to full, then one consume reopens one slot
    for (int i = 0; i < 16; i++) expectWord(32'(4 * i), 4'(i));
    expectWord(32'h40, 4'd0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      sample();
      if (full) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) failNow("fill timeout");
    checkOutput("fill occupancy", occupancy, 16);
    checkOutput("fill mem_req", mem_req, 0);
    repeat (3) sample();
    checkOutput("full holds mem_req", mem_req, 0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    checkOutput("after consume occupancy", occupancy, 15);
    checkOutput("after consume mem_req", mem_req, 0);
    sample();
    checkOutput("refetch mem_req", mem_req, 1);
    checkOutput("refetch mem_addr", mem_addr, 32'h40);
    waitWrites(17, "refill");
    sample();
    sample();
    checkOutput("refull full", full, 1);
    checkOutput("refull occupancy", occupancy, 16);
    checkOutput("refull mem_req", mem_req, 0);

    // Continuous fetch with a consume on every capture, wrapping the index
    applyReset();
    bw = write_seen;
    bg = grant_seen;
    for (int i = 0; i < 22; i++) expectWord(32'(4 * i), 4'(i % 16));
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitWrites(bw + 2, "stream prefill");
    auto_consume = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      sample();
      if (grant_seen >= bg + 22) begin
        hit = 1'b1;
        break;
      end
      checkOutput("stream occupancy", occupancy, 2);
    end
    if (!hit) failNow("stream timeout");
    step();
    fetch_en = 1'b0;
    waitWrites(bw + 22, "stream");
    auto_consume = 1'b0;
    instr_consume = 1'b0;
    sample();
    checkOutput("stream end occupancy", occupancy, 2);
    checkOutput("stream end mem_req", mem_req, 0);

    // Redirect while waiting: in-flight response dropped, restart at 0x100
    applyReset();
    resp_delay = 1;
    bw = write_seen;
    bg = grant_seen;
    expectWord(32'h0, 4'd0);
    expectGrant(32'h4);
    expectWord(32'h100, 4'd0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitGrants(bg + 2, "redirect setup");
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    checkOutput("redirect occupancy", occupancy, 0);
    checkOutput("drain mem_req", mem_req, 0);
    sample();
    checkOutput("dropped word pulse", buf_wr_pulse, 0);
    checkOutput("restart mem_req", mem_req, 1);
    checkOutput("restart mem_addr", mem_addr, 32'h100);
    waitGrants(bg + 3, "restart");
    step();
    fetch_en = 1'b0;
    waitWrites(bw + 2, "restart");
    sample();
    checkOutput("restart occupancy", occupancy, 1);
    checkOutput("restart buf_index", buf_index, 0);

    // Reset mid-transaction; the late response must not be written
    applyReset();
    resp_delay = 2;
    bw = write_seen;
    bg = grant_seen;
    expectWord(32'h0, 4'd0);
    expectGrant(32'h4);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitGrants(bg + 2, "midreset setup");
    step();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    #1;
    checkOutput("midreset mem_req", mem_req, 0);
    checkOutput("midreset mem_addr", mem_addr, 0);
    checkOutput("midreset occupancy", occupancy, 0);
    checkOutput("midreset full", full, 0);
    checkOutput("midreset buf_wr_pulse", buf_wr_pulse, 0);
    checkOutput("midreset buf_index", buf_index, 0);
    checkOutput("midreset buf_instr", buf_instr, 0);
    step();
    rst_n = 1'b1;
    repeat (5) sample();
    checkOutput("late response occupancy", occupancy, 0);
    checkOutput("late response writes", write_seen, bw + 1);
    resp_delay = 0;

    checkOutput("addr queue drained", addr_q.size(), 0);
    checkOutput("write queue drained", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 Parameter INSTR_WORD_SIZE, default 32, width of one instruction word.
REQ-002 Parameter BS, default 16, number of instruction buffer slots; power of two.
REQ-003 Parameter ADDR_W, default 32, fetch address width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 fetch_en  input  1  permits new fetch requests.
REQ-008 redirect_valid  input  1  single-cycle pulse; flush and restart at redirect_pc.
REQ-009 redirect_pc  input  ADDR_W  restart address.
REQ-010 instr_consume  input  1  single-cycle pulse; downstream has taken one buffered instruction.
REQ-011 mem_req  output  1  fetch request, held until mem_gnt.
REQ-012 mem_addr  output  ADDR_W  fetch address (pc).
REQ-013 mem_gnt  input  1  request accepted.
REQ-014 mem_rvalid  input  1  read data valid.
REQ-015 mem_rdata  input  INSTR_WORD_SIZE  read data.
REQ-016 buf_instr  output  INSTR_WORD_SIZE  word written into the instruction buffer.
REQ-017 buf_index  output  clog2(BS)  instruction buffer slot index.
REQ-018 buf_wr_pulse  output  1  high for one cycle when buf_instr/buf_index carry a new word.
REQ-019 occupancy  output  clog2(BS)+1  buffered, unconsumed instructions.
REQ-020 full  output  1  occupancy == BS.

Function
REQ-021 The instruction buffer writes every cycle, so buf_instr and buf_index SHALL hold their last values whenever buf_wr_pulse is low (same word rewritten into the same slot).
REQ-022 FSM states: IDLE, REQ, WAIT, FULL, DRAIN.
REQ-023 IDLE: mem_req=0; go to REQ when fetch_en=1 and full=0.
REQ-024 REQ: mem_req=1, mem_addr=pc; on mem_gnt go to WAIT.
REQ-025 WAIT: on mem_rvalid register buf_instr=mem_rdata, buf_index=wr_ptr, buf_wr_pulse=1 next cycle; wr_ptr+1 mod BS; pc+4 mod 2^ADDR_W; occupancy+1.
REQ-026 After a WAIT capture: go to FULL if new occupancy == BS, else REQ if fetch_en=1, else IDLE.
REQ-027 FULL: mem_req=0; leave to REQ (fetch_en=1) or IDLE on the cycle after occupancy drops below BS.
REQ-028 Latency: mem_rvalid at cycle N gives buf_wr_pulse at N+1; a new mem_req can be asserted no earlier than N+1.
REQ-029 instr_consume with occupancy 0 SHALL be ignored; capture and consume in the same cycle leave occupancy unchanged.
REQ-030 redirect_valid (any state): pc=redirect_pc, wr_ptr=0, occupancy=0, buf_wr_pulse=0; from WAIT, or REQ with mem_gnt in the same cycle, go to DRAIN, otherwise to REQ/IDLE per fetch_en.
REQ-031 DRAIN: mem_req=0; discard the next mem_rvalid (no buffer write), then go to REQ/IDLE per fetch_en.
REQ-032 redirect_valid wins over simultaneous instr_consume and mem_rvalid.
REQ-033 wr_ptr wraps from BS-1 to 0 without a gap cycle.

Reset
REQ-034 On rst_n low, asynchronously: state=IDLE, pc=0, wr_ptr=0, occupancy=0, mem_req=0, mem_addr=0, buf_instr=0, buf_index=0, buf_wr_pulse=0, full=0.
REQ-035 Reset mid-transaction SHALL abandon the transaction; a response arriving after reset release in IDLE SHALL be ignored.

Structure
REQ-036 Shared package instr_fetch_pkg SHALL hold the FSM state enum and the PC increment constant (4).
REQ-037 No sub-module; the FSM, pointers and counter reside in instr_fetch_seq.

Verification
REQ-038 Reset, fetch_en=1, mem_gnt and mem_rvalid one cycle after each request -> mem_addr 0,4,8,...; buf_index 0,1,2,...; one buf_wr_pulse per word.
REQ-039 Fetch 16 words without consume (BS=16) -> full=1, state FULL, mem_req=0; one instr_consume -> occupancy 15, mem_req reasserted next cycle.
REQ-040 Continuous fetch and consume for 20 words -> buf_index wraps 15->0, occupancy stays constant through simultaneous capture and consume.
REQ-041 redirect_valid with redirect_pc=0x100 while in WAIT -> next mem_rvalid dropped (no buf_wr_pulse), then mem_addr=0x100, buf_index=0, occupancy=0.
REQ-042 rst_n low during WAIT -> all outputs at reset values immediately; a late mem_rvalid causes no buffer write.
